// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// drain defaults and the register-match helper used by the hazard compare.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hazState_e;

  localparam int DRAIN_CYCLES_DEF = 4;
  localparam int DRAIN_W          = 4;

  // Register $zero never carries a dependency, so it never matches.
  function automatic logic isRegMatch(input logic [4:0] producer,
                                      input logic [4:0] consumer);
    return (producer != 5'd0) && (producer == consumer);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle seen by the hazard controller: register fields and
// branch/halt requests in, load enables, flushes and counters out.
interface hazard_ctrl_if #(parameter int CNT_W = 16);

  logic [4:0]       IdRs;
  logic [4:0]       IdRt;
  logic [4:0]       ExRt;
  logic             ExMRead;
  logic             BranchTaken;
  logic             HaltReq;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IDEXBubble;
  logic             IFIDFlush;
  logic             IDEXFlush;
  logic             EXMEMFlush;
  logic             HaltAck;
  logic [CNT_W-1:0] StallCnt;
  logic [CNT_W-1:0] FlushCnt;

  modport master (
    output IdRs, IdRt, ExRt, ExMRead, BranchTaken, HaltReq,
    input  PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, IDEXFlush, EXMEMFlush,
    input  HaltAck, StallCnt, FlushCnt
  );

  modport slave (
    input  IdRs, IdRt, ExRt, ExMRead, BranchTaken, HaltReq,
    output PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, IDEXFlush, EXMEMFlush,
    output HaltAck, StallCnt, FlushCnt
  );

endinterface

// File: rtl/hazard_ctrl_detect.sv
// Combinational load-use compare between the load in ID/EX and the
// instruction waiting in IF/ID.
module hazard_detect
  import hazard_ctrl_pkg::*;
(
  input  logic       enable,
  input  logic [4:0] idRs,
  input  logic [4:0] idRt,
  input  logic [4:0] exRt,
  input  logic       exMRead,
  output logic       loadUse
);

  always_comb begin
    loadUse = enable && exMRead &&
              (isRegMatch(exRt, idRs) || isRegMatch(exRt, idRt));
  end

endmodule

// File: rtl/hazard_ctrl_satcnt.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_cnt #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stalls, branch flushes and halt/drain
// sequencing for the five-stage pipeline, plus stall/flush counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 16
) (
  input  logic          CLK,
  input  logic          RSTn,
  hazard_ctrl_if.slave  bus
);

  hazState_e          state;
  hazState_e          nextState;
  logic [DRAIN_W-1:0] drainCnt;
  logic [DRAIN_W-1:0] nextDrain;

  logic loadUse;
  logic stallNow;
  logic pcWrite;
  logic ifidWrite;
  logic idexBubble;
  logic flushAll;
  logic haltAck;

  logic [CNT_W-1:0] stallCount;
  logic [CNT_W-1:0] flushCount;

  hazard_detect uDetect (
    .enable  (state == RUN),
    .idRs    (bus.IdRs),
    .idRt    (bus.IdRt),
    .exRt    (bus.ExRt),
    .exMRead (bus.ExMRead),
    .loadUse (loadUse)
  );

  // A taken branch squashes the dependent instruction anyway, so no stall.
  assign stallNow = loadUse && !bus.BranchTaken;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= RUN;
      drainCnt <= '0;
    end else begin
      state    <= nextState;
      drainCnt <= nextDrain;
    end
  end

  always_comb begin
    nextState  = state;
    nextDrain  = drainCnt;
    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    idexBubble = 1'b0;
    flushAll   = 1'b0;
    haltAck    = 1'b0;

    case (state)
      RUN: begin
        if (stallNow) begin
          pcWrite    = 1'b0;
          ifidWrite  = 1'b0;
          idexBubble = 1'b1;
        end
        if (bus.HaltReq) begin
          nextState = DRAIN;
          nextDrain = DRAIN_W'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        pcWrite    = 1'b0;
        ifidWrite  = 1'b0;
        idexBubble = 1'b1;
        nextDrain  = drainCnt - 1'b1;
        if (drainCnt <= DRAIN_W'(1)) begin
          nextState = HALTED;
        end
      end
      HALTED: begin
        pcWrite    = 1'b0;
        ifidWrite  = 1'b0;
        idexBubble = 1'b1;
        haltAck    = 1'b1;
        if (!bus.HaltReq) begin
          nextState = RUN;
        end
      end
      default: begin
        nextState = RUN;
        nextDrain = '0;
      end
    endcase

    // Branch redirect wins in every state but leaves the drain countdown alone.
    if (bus.BranchTaken) begin
      pcWrite  = 1'b1;
      flushAll = 1'b1;
    end

    if (!RSTn) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexBubble = 1'b1;
      flushAll   = 1'b1;
      haltAck    = 1'b0;
    end
  end

  sat_cnt #(.W(CNT_W)) uStallCnt (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .inc   (stallNow),
    .count (stallCount)
  );

  sat_cnt #(.W(CNT_W)) uFlushCnt (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .inc   (bus.BranchTaken),
    .count (flushCount)
  );

  assign bus.PCWrite    = pcWrite;
  assign bus.IFIDWrite  = ifidWrite;
  assign bus.IDEXBubble = idexBubble;
  assign bus.IFIDFlush  = flushAll;
  assign bus.IDEXFlush  = flushAll;
  assign bus.EXMEMFlush = flushAll;
  assign bus.HaltAck    = haltAck;
  assign bus.StallCnt   = stallCount;
  assign bus.FlushCnt   = flushCount;

endmodule
